// File: rtl/conv_pkg.sv
// Shared definitions for the CNN datapath: feature-map geometry, sample widths
// and the max / ReLU-shift-saturate helpers reused by later layers.
package conv_pkg;

    localparam int SUM_BW    = 16;
    localparam int DATA_BW   = 8;
    localparam int OUT_SIZE  = 28;
    localparam int POOL_SIZE = OUT_SIZE / 2;
    localparam int CNT_BW    = 5;

    localparam logic [DATA_BW-1:0] DATA_MAX = DATA_BW'(2 ** (DATA_BW - 1) - 1);
    localparam logic [SUM_BW:0]    SAT_MAX  = (SUM_BW + 1)'(2 ** (DATA_BW - 1) - 1);

    function automatic logic signed [SUM_BW-1:0] smax(
        input logic signed [SUM_BW-1:0] a,
        input logic signed [SUM_BW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Extended by one bit so the rounding add can never wrap.
    function automatic logic [DATA_BW-1:0] relu_shift_sat(
        input logic signed [SUM_BW-1:0] v,
        input int                       shift,
        input bit                       round_en
    );
        logic [SUM_BW:0] ext;
        ext = (v < 0) ? '0 : {1'b0, v};
        if (round_en && shift > 0)
            ext = ext + ((SUM_BW + 1)'(1) << (shift - 1));
        ext = ext >> shift;
        return (ext > SAT_MAX) ? DATA_MAX : ext[DATA_BW-1:0];
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row buffer of horizontal maxima: a single write port and an
// asynchronous read port, kept separate so it can map onto distributed RAM.
module pool_line_buf #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are always written on an even row before the odd row reads them.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool.sv
// 2x2 stride-2 max-pool + ReLU + requantize on the conv raster stream.
// Optional build macro POOL_ROUND_EN: round-half-up before the shift.
module relu_maxpool
    import conv_pkg::*;
#(
    parameter int SUM_BW   = conv_pkg::SUM_BW,
    parameter int DATA_BW  = conv_pkg::DATA_BW,
    parameter int OUT_SIZE = conv_pkg::OUT_SIZE,
    parameter int CNT_BW   = conv_pkg::CNT_BW,
    parameter int SHIFT    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [SUM_BW-1:0]  i_y,
    input  logic                      i_valid,
    output logic        [DATA_BW-1:0] o_x,
    output logic                      o_valid,
    output logic                      o_frame_done
);

`ifdef POOL_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    localparam logic [CNT_BW-1:0] LAST = CNT_BW'(OUT_SIZE - 1);

    logic        [CNT_BW-1:0] col;
    logic        [CNT_BW-1:0] row;
    logic signed [SUM_BW-1:0] h_reg;
    logic signed [SUM_BW-1:0] hmax;
    logic signed [SUM_BW-1:0] line_entry;
    logic signed [SUM_BW-1:0] pmax;
    logic                     buf_we;
    logic                     pool_fire;

    assign hmax      = smax(h_reg, i_y);
    assign pmax      = smax(line_entry, hmax);
    assign buf_we    = i_valid & ~row[0] & col[0];
    assign pool_fire = i_valid &  row[0] & col[0];

    pool_line_buf #(
        .DEPTH (OUT_SIZE / 2),
        .WIDTH (SUM_BW),
        .AW    (CNT_BW - 1)
    ) u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (col[CNT_BW-1:1]),
        .wdata (hmax),
        .raddr (col[CNT_BW-1:1]),
        .rdata (line_entry)
    );

    // Raster position and the left half of the current horizontal pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            h_reg <= '0;
        end else if (i_valid) begin
            if (!col[0])
                h_reg <= i_y;
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Output registers: one pooled sample per completed 2x2 window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_x          <= '0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_valid      <= pool_fire;
            o_frame_done <= pool_fire && row == LAST && col == LAST;
            o_x          <= pool_fire ? relu_shift_sat(pmax, SHIFT, ROUND_EN) : '0;
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool: two instances (SHIFT=0 and SHIFT=4)
// share one input stream; expected pooled samples are queued at issue time.
module tb_relu_maxpool;

    localparam int N  = 28;
    localparam int NP = 196;

    typedef struct {
        logic [7:0] x;
        bit         done;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] i_y = '0;
    logic               i_valid = 1'b0;
    logic [7:0]         o_x0, o_x4;
    logic               o_valid0, o_valid4;
    logic               o_done0, o_done4;

    int   frm [N][N];
    exp_t q0 [$];
    exp_t q4 [$];
    int   checks = 0;
    int   errors = 0;
    logic prev_acc = 1'b0;

    always #5 clk = ~clk;

    relu_maxpool #(.SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_y(i_y), .i_valid(i_valid),
        .o_x(o_x0), .o_valid(o_valid0), .o_frame_done(o_done0)
    );

    relu_maxpool #(.SHIFT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_y(i_y), .i_valid(i_valid),
        .o_x(o_x4), .o_valid(o_valid4), .o_frame_done(o_done4)
    );

    function automatic logic [7:0] expect_val(input int v, input int sh);
        int t;
        t = (v < 0) ? 0 : v;
`ifdef POOL_ROUND_EN
        if (sh > 0)
            t = t + (1 << (sh - 1));
`endif
        t = t >>> sh;
        if (t > 127)
            t = 127;
        return 8'(t);
    endfunction

    function automatic int max4(input int r, input int c);
        int m;
        m = frm[r-1][c-1];
        if (frm[r-1][c] > m) m = frm[r-1][c];
        if (frm[r][c-1]  > m) m = frm[r][c-1];
        if (frm[r][c]    > m) m = frm[r][c];
        return m;
    endfunction

    task automatic applyStimulus(input int n_samples, input bit gaps);
        int r, c, m;
        exp_t e;
        for (int idx = 0; idx < n_samples; idx++) begin
            r = idx / N;
            c = idx % N;
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                    @(negedge clk);
                    i_valid = 1'b0;
                    i_y     = 16'($urandom);
                end
            end
            @(negedge clk);
            i_valid = 1'b1;
            i_y     = 16'(frm[r][c]);
            if (r % 2 == 1 && c % 2 == 1) begin
                m      = max4(r, c);
                e.done = (r == N - 1 && c == N - 1);
                e.x    = expect_val(m, 0);
                q0.push_back(e);
                e.x    = expect_val(m, 4);
                q4.push_back(e);
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_y     = '0;
    endtask

    task automatic checkOutput(input int which, input logic v, input logic [7:0] x,
                               input logic fd);
        exp_t e;
        if (v && !prev_acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL valid_after_idle dut%0d: o_valid=1 required 0", which);
        end
        if (!v) begin
            checks++;
            if (x !== 8'd0 || fd !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_outputs dut%0d: o_x=%0d done=%0b required 0/0", which, x, fd);
            end
        end else begin
            checks++;
            if ((which == 0 && q0.size() == 0) || (which == 4 && q4.size() == 0)) begin
                errors++;
                $display("[TB] FAIL unexpected_output dut%0d: o_x=%0d required no output", which, x);
            end else begin
                e = (which == 0) ? q0.pop_front() : q4.pop_front();
                if (x !== e.x || fd !== e.done) begin
                    errors++;
                    $display("[TB] FAIL pooled_sample dut%0d: o_x=%0d done=%0b required %0d/%0b",
                             which, x, fd, e.x, e.done);
                end
            end
        end
    endtask

    always @(posedge clk) prev_acc <= i_valid;

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput(0, o_valid0, o_x0, o_done0);
            checkOutput(4, o_valid4, o_x4, o_done4);
        end
    end

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((q0.size() != 0 || q4.size() != 0) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (q0.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_%s: pending=%0d/%0d required 0/0", name, q0.size(), q4.size());
            q0.delete();
            q4.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkReset(input string name);
        checks++;
        if (o_valid0 !== 1'b0 || o_valid4 !== 1'b0 || o_x0 !== 8'd0 || o_x4 !== 8'd0 ||
            o_done0 !== 1'b0 || o_done4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: valid=%0b/%0b x=%0d/%0d done=%0b/%0b required all 0",
                     name, o_valid0, o_valid4, o_x0, o_x4, o_done0, o_done4);
        end
    endtask

    task automatic fillRamp(input int scale, input int offset);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                frm[r][c] = (r * N + c) * scale + offset;
    endtask

    task automatic fillConst(input int v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                frm[r][c] = v;
    endtask

    initial begin
        #12;
        checkReset("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] ramp frame, continuous valid");
        fillRamp(1, 0);
        applyStimulus(N * N, 1'b0);
        drain("ramp");

        $display("[TB] all-negative frame");
        fillConst(-5);
        applyStimulus(N * N, 1'b0);
        drain("negative");

        $display("[TB] directed windows: shift, saturation, rounding");
        fillConst(-5);
        frm[0][0] = 300;  frm[0][1] = -2;  frm[1][0] = 17;  frm[1][1] = 1000;
        frm[1][2] = 5000;
        frm[0][4] = 24;   frm[1][5] = 3;
        frm[27][27] = -32768;
        applyStimulus(N * N, 1'b0);
        drain("windows");

        $display("[TB] ramp frame with random valid gaps");
        fillRamp(1, 0);
        applyStimulus(N * N, 1'b1);
        drain("gaps");

        $display("[TB] reset in the middle of a frame");
        fillRamp(3, -100);
        applyStimulus(9 * N + 13, 1'b0);
        drain("partial");
        #2 rst_n = 1'b0;
        #1 checkReset("mid_frame_reset");
        @(negedge clk);
        rst_n = 1'b1;
        fillRamp(7, -2000);
        applyStimulus(N * N, 1'b1);
        drain("fresh");

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/relu_maxpool.md
Name: relu_maxpool

Overview:
- Downstream stage of the convolution core; consumes its valid-qualified raster output stream (o_y/o_valid) of OUT_SIZE x OUT_SIZE signed partial sums.
- Applies 2x2 stride-2 max-pooling, ReLU and requantization back to DATA_BW.
- Produces a pooled (OUT_SIZE/2)^2 stream in a format that feeds the next convolution layer's i_x/i_valid.

Parameters:
- SUM_BW, 16: input sample width (signed), matches conv output.
- DATA_BW, 8: output sample width (signed, result always >= 0).
- OUT_SIZE, 28: conv output row length and row count (default (32-5)/1+1); must be even and >= 2.
- CNT_BW, 5: width of column/row counters; must hold OUT_SIZE-1.
- SHIFT, 4: arithmetic right shift applied before saturation; range 0..SUM_BW-1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- i_y  input  SUM_BW  signed conv result; sampled only when i_valid=1.
- i_valid  input  1  input sample strobe; gaps of any length allowed, no backpressure.
- o_x  output  DATA_BW  pooled, ReLU'd, requantized sample; 0 when o_valid=0.
- o_valid  output  1  one-cycle strobe per pooled sample.
- o_frame_done  output  1  one-cycle pulse with the last pooled sample of a frame.

Behaviour:
- Interface: one clock (clk); reset rst_n asynchronous, active-low.
- Reset values: o_x=0, o_valid=0, o_frame_done=0, col=0, row=0, horizontal register=0. Line buffer contents need no reset, because they are always written before they are read.
- Counters:
  - col increments on each accepted sample and wraps OUT_SIZE-1 -> 0.
  - row increments on the col wrap and wraps OUT_SIZE-1 -> 0.
  - Cycles with i_valid=0 leave all state unchanged.
- Horizontal stage:
  - Even col: store i_y in h_reg.
  - Odd col: hmax = signed max(h_reg, i_y).
- Line buffer: OUT_SIZE/2 entries of SUM_BW, addressed by col>>1.
  - Even row, odd col: write hmax.
  - Odd row, odd col: read the entry, form pmax = signed max(entry, hmax).
- Post-processing on pmax:
  - ReLU: negative values become 0.
  - Arithmetic shift right by SHIFT.
  - Saturate to 2^(DATA_BW-1)-1.
- Output timing:
  - o_x and o_valid are registered; latency is exactly 1 clk from the accepting edge of the (odd row, odd col) input.
  - o_valid is low in all other cycles.
  - o_frame_done is asserted together with o_valid for row=OUT_SIZE-1, col=OUT_SIZE-1. Counters wrap on that same edge and the next sample starts a new frame with no idle cycle needed.
- Back-to-back: with continuous i_valid, output rate is one sample every 2 cycles on odd rows and none on even rows.
- Equal values: the max of equal values is that value; there is no tie-priority requirement.
- Reset mid-frame: all counters return to 0 asynchronously. The next accepted sample is treated as frame position (0,0), and any partial pooled window is discarded without output.
- Width rule: all comparisons are signed at SUM_BW. The shift is applied to the non-negative value, so no sign handling is needed after ReLU.

Optional Feature:
- Macro POOL_ROUND_EN.
- Defined: before the shift, add 2^(SHIFT-1) when SHIFT>0 (round-half-up). Saturation is applied after rounding, and the add is computed at SUM_BW+1 bits so it cannot overflow.
- Undefined: plain truncating shift.
- Latency is unchanged in both builds.

Decomposition:
- Shared package (conv_pkg):
  - localparams OUT_SIZE and POOL_SIZE=OUT_SIZE/2.
  - max-positive constant for DATA_BW.
  - a function for signed max and a function for relu_shift_sat, reused by later layers.
- One sub-module, pool_line_buf: a POOL_SIZE x SUM_BW register array with one write port and one combinational read port. It is separated so it can later be mapped to distributed RAM.

Test Plan:
- Ramp input (i_y=row*OUT_SIZE+col, continuous valid), SHIFT=0 -> outputs (r,c) = min(127, (2r+1)*28+2c+1). First output o_x=29 arrives 1 clk after input index 29. 196 strobes per frame, o_frame_done only on the 196th.
- All-negative frame (i_y=-5) -> 196 outputs, all o_x=0.
- Window {300, -2, 17, 1000} with SHIFT=4 -> o_x=62 (1000>>4). Value 5000 -> saturates to 127.
- POOL_ROUND_EN defined, window max 24, SHIFT=4 -> o_x=2; without the macro -> o_x=1.
- Random i_valid gaps (≈50% duty) with the ramp frame -> identical output sequence to continuous input. o_valid never high in a cycle following i_valid=0.
- rst_n pulsed low at row 9 col 13, then a fresh frame -> first output equals the fresh frame's window (0,0). No stale output, and o_frame_done fires after exactly 196 outputs.
